// File: rtl/sparse_pkg.sv
// Shared types for the 2:4 structured-sparsity weight path feeding sparse_core.
package sparse_pkg;

  localparam int PE_ROWS = 4;

  typedef logic signed [7:0] weight_t;
  typedef weight_t [0:3] dense_group_t;

  typedef struct packed {
    logic signed [7:0] val0;
    logic signed [7:0] val1;
    logic [1:0]        idx0;
    logic [1:0]        idx1;
  } sparse_packet_t;

endpackage

// File: rtl/sparse_group_enc.sv
// Combinational 2:4 pruner: keeps the two largest-magnitude weights of a group.
module sparse_group_enc
  import sparse_pkg::*;
(
  input  dense_group_t   group,
  output sparse_packet_t pkt,
  output logic           lossy
);

  logic [8:0] mag [4];
  logic [2:0] rank [4];
  logic [3:0] keep;
  logic [3:0] nz;
  logic [1:0] idx0;
  logic [1:0] idx1;

  // A weight's rank is how many others beat it; equal magnitudes favour the lower index.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      mag[k] = group[k][7] ? (~{group[k][7], group[k]} + 9'd1) : {1'b0, group[k]};
      nz[k]  = |group[k];
    end
    for (int k = 0; k < 4; k++) begin
      rank[k] = 3'd0;
      for (int j = 0; j < 4; j++) begin
        if (j != k && (mag[j] > mag[k] || (mag[j] == mag[k] && j < k)))
          rank[k] = rank[k] + 3'd1;
      end
      keep[k] = (rank[k] < 3'd2);
    end
  end

  always_comb begin
    idx0 = keep[0] ? 2'd0 : (keep[1] ? 2'd1 : 2'd2);
    idx1 = keep[3] ? 2'd3 : (keep[2] ? 2'd2 : 2'd1);
    pkt.idx0 = idx0;
    pkt.idx1 = idx1;
    pkt.val0 = group[idx0];
    pkt.val1 = group[idx1];
    lossy    = |(~keep & nz);
  end

endmodule

// File: rtl/sparse_weight_encoder.sv
// Streaming 2:4 encoder with a two-bank ping-pong buffer of 4-row issues.
module sparse_weight_encoder
  import sparse_pkg::*;
#(
  parameter int ROWS  = PE_ROWS,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  dense_group_t                in_group,
  output logic                        out_valid,
  input  logic                        out_ready,
  output sparse_packet_t [0:ROWS-1]   w_rows,
  output logic [CNT_W-1:0]            lossy_cnt
);

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;
  localparam logic [1:0] LAST_ROW     = 2'(ROWS - 1);

  sparse_packet_t [0:ROWS-1] bank [2];
  logic [1:0]                state [2];
  logic                      wr_bank;
  logic                      rd_bank;
  logic [1:0]                row_cnt;

  sparse_packet_t enc_pkt;
  logic           enc_lossy;
  logic           accept;
  logic           issue;

  sparse_group_enc u_enc (
    .group (in_group),
    .pkt   (enc_pkt),
    .lossy (enc_lossy)
  );

  // Handshake flags depend only on registered bank state.
  assign in_ready  = (state[wr_bank] != BANK_FULL);
  assign out_valid = (state[rd_bank] == BANK_FULL);
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;
  assign w_rows    = bank[rd_bank];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= BANK_EMPTY;
        bank[b]  <= '0;
      end
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      row_cnt   <= 2'd0;
      lossy_cnt <= '0;
    end else begin
      // Issue and accept never target the same bank in one cycle.
      if (issue) begin
        state[rd_bank] <= BANK_EMPTY;
        rd_bank        <= ~rd_bank;
      end
      if (accept) begin
        bank[wr_bank][row_cnt] <= enc_pkt;
        if (row_cnt == LAST_ROW) begin
          state[wr_bank] <= BANK_FULL;
          wr_bank        <= ~wr_bank;
          row_cnt        <= 2'd0;
        end else begin
          state[wr_bank] <= BANK_FILLING;
          row_cnt        <= row_cnt + 2'd1;
        end
        if (enc_lossy && lossy_cnt != {CNT_W{1'b1}})
          lossy_cnt <= lossy_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/sparse_weight_encoder.md
# sparse_weight_encoder

Streaming 2:4 structured-sparsity encoder that produces the weight-row packets consumed by `sparse_core`. It accepts dense int8 weight groups one row per beat, prunes each group of four to its two largest-magnitude entries, and packs four consecutive rows into one `w_rows[0:3]` issue. A ping-pong buffer of two 4-row banks decouples the dense input stream from core issue. A saturating counter reports lossy pruning.

## Interface
- `ROWS`, 4, rows per issue; fixed to the `sparse_core` PE count.
- `CNT_W`, 16, width of `lossy_cnt`.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low; one clock
- `in_valid`  in  1  dense group valid
- `in_ready`  out  1  encoder can accept a group
- `in_group`  in  4×8 signed  dense weights `[0:3]` of one row
- `out_valid`  out  1  `w_rows` holds a complete 4-row issue
- `out_ready`  in  1  core consumes the issue
- `w_rows`  out  `sparse_packet_t [0:3]`  encoded rows, index 0 = first accepted row
- `lossy_cnt`  out  CNT_W  groups whose dropped entries were not both zero; saturating

## Operation
- Encode rule per group:
  - `mag[k] = |in_group[k]|`, 9-bit unsigned, so -128 gives 128.
  - Keep the two largest magnitudes. Ties go to the lower index.
  - Emit with `idx0 < idx1`: `val0 = in_group[idx0]`, `val1 = in_group[idx1]`. Values keep their sign.
  - All-zero group: `idx0=0`, `idx1=1`, values 0.
- Lossy rule: if either dropped entry is nonzero, `lossy_cnt` increments by 1 in the accept cycle + 1. It holds at `2^CNT_W-1`.
- Banks: two banks (0,1), each with state EMPTY → FILLING → FULL → EMPTY.
  - Write side: `wr_bank`, `row_cnt` 0..3.
    - A beat is accepted when `in_valid && in_ready`. Its encoded packet is written to `bank[wr_bank].row[row_cnt]`.
    - On row_cnt 3 the bank goes FULL, `wr_bank` toggles and `row_cnt` returns to 0.
  - Read side: `rd_bank` points to the oldest FULL bank.
    - `out_valid` = `bank[rd_bank]` is FULL.
    - On `out_valid && out_ready` the bank goes EMPTY and `rd_bank` toggles.
  - `in_ready` = `bank[wr_bank]` is not FULL.
- Simultaneous accept and issue in one cycle is legal. Both take effect, including the case where the freed bank is immediately written.
- `w_rows` is stable while `out_valid && !out_ready`. Its value is don't-care when `out_valid=0`.
- Partial banks are never issued. There is no flush; the producer always sends multiples of 4 rows.

## Timing
- Reset, sampled on `clk` with `rst_n=0`:
  - both banks EMPTY, `wr_bank=rd_bank=0`, `row_cnt=0`
  - `out_valid=0`, `lossy_cnt=0`, `w_rows` = all-zero packets
  - `in_ready=1` from the first cycle after reset
- Reset mid-operation discards both banks' contents and the lossy count, and restarts at row 0.
- Latency: 4th row accepted at cycle N → `out_valid=1` at N+1, because encoding is registered into the bank.
- Throughput: one group per cycle sustained while `out_ready` holds 1 for at least one cycle per 4. With `out_ready=0`, exactly 8 groups are accepted, then `in_ready=0`.
- `in_ready` and `out_valid` are derived from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Structure
- `sparse_pkg` holds:
  - `sparse_packet_t`: `val0`, `val1` signed 8; `idx0`, `idx1` 2-bit
  - `dense_group_t`: 4×signed 8
  - constant `PE_ROWS = 4`
- Sub-module `sparse_group_enc`: purely combinational. Inputs: `dense_group_t`. Outputs: `sparse_packet_t` and `lossy` flag. It is instantiated once, on the input path.
- The top level holds the bank registers, pointers, state and the counter.

## Test plan
- Encode values, checked in bank row order:
  - `{5,-9,0,3}` → `idx0=0 val0=5`, `idx1=1 val1=-9`; lossy, so `lossy_cnt` goes 0→1.
  - `{-128,127,0,0}` → `(0,-128),(1,127)`; not lossy.
  - `{2,2,2,2}` → `idx 0,1`, values 2,2; lossy.
  - `{0,0,0,0}` → `idx 0,1`, values 0; not lossy.
  - `{0,0,7,-7}` → `(2,7),(3,-7)`; not lossy.
- Backpressure: `out_ready=0`, `in_valid=1` continuously.
  - Exactly 8 accepts, then `in_ready=0`.
  - `w_rows` holds rows 0–3 unchanged.
  - Raise `out_ready` for 1 cycle → rows 4–7 are presented next cycle, and `in_ready=1`.
- Streaming: `out_ready=1`, 16 consecutive groups.
  - 4 issues, first `out_valid` at cycle after 4th accept.
  - No `in_ready` drop; row order is preserved.
- Simultaneous: both banks FULL; in one cycle `out_ready=1` and `in_valid=1`.
  - One issue occurs.
  - The beat after `in_ready` rises lands in row 0 of the freed bank.
- Reset mid-fill: after 2 accepted rows, assert `rst_n=0` for one cycle.
  - `out_valid=0`, `lossy_cnt=0`.
  - Next 4 rows issue as one complete bank.
- Saturation (CNT_W=4): 20 lossy groups → `lossy_cnt` stops at 15.
